// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end, one bit per clk, with a one-word holding buffer
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             word_start,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, buf_q, buf_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic buf_full_q, buf_full_d, data_q, data_d, dv_q, dv_d, ws_q, ws_d, wd_q, wd_d;
  logic xfer, last, load, direct;
  assign in_ready   = !buf_full_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign word_start = ws_q;
  assign word_done  = wd_q;
  // data_q already shows the bit at cnt_q, so the shift reg holds only the bits still to come
  always_comb begin
    xfer       = in_valid && in_ready;
    last       = state_q == SHIFT && cnt_q == LAST;
    load       = state_q == IDLE ? xfer : last && (buf_full_q || xfer);
    direct     = xfer && (state_q == IDLE || last);
    nxt        = buf_full_q ? buf_q : in_data;
    state_d    = (load || (state_q == SHIFT && !last)) ? SHIFT : IDLE;
    cnt_d      = (state_q == SHIFT && !last) ? cnt_q + CW'(1) : '0;
    sh_d       = load ? (MSB_FIRST ? nxt << 1 : nxt >> 1) : (MSB_FIRST ? sh_q << 1 : sh_q >> 1);
    data_d     = load ? (MSB_FIRST ? nxt[WIDTH-1] : nxt[0]) :
                 state_d == SHIFT ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    dv_d       = state_d == SHIFT;
    ws_d       = load;
    wd_d       = state_d == SHIFT && cnt_d == LAST;
    buf_full_d = buf_full_q ? !last : xfer && !direct;
    buf_d      = (xfer && !direct) ? in_data : buf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      data_q     <= IDLE_BIT;
      dv_q       <= 1'b0;
      ws_q       <= 1'b0;
      wd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      ws_q       <= ws_d;
      wd_q       <= wd_d;
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard bench driving an MSB-first and an LSB-first feeder in parallel
module tb_serial_bit_feeder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, run = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy [2], d [2], dv [2], ws [2], wd [2];
  logic [2:0] q [2][$];
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .data(d[0]), .data_valid(dv[0]), .word_start(ws[0]), .word_done(wd[0]));
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .data(d[1]), .data_valid(dv[1]), .word_start(ws[1]), .word_done(wd[1]));

  // Each expected entry is {bit, first-bit flag, last-bit flag}, in transmission order
  task automatic push(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q[0].push_back({w[W-1-i], i == 0, i == W - 1});
      q[1].push_back({w[i], i == 0, i == W - 1});
    end
  endtask

  task automatic chk(input int k);
    logic [2:0] e;
    logic buffered;
    vectors++;
    if (dv[k]) begin
      if (q[k].size() == 0) begin
        errors++;
        $display("FAIL extra_bit dut%0d: got data_valid=1 want no pending bit", k);
      end else begin
        e = q[k].pop_front();
        if ({d[k], ws[k], wd[k]} !== e) begin
          errors++;
          $display("FAIL bit dut%0d: got {data,start,done}=%b want %b", k, {d[k], ws[k], wd[k]}, e);
        end
      end
    end else if (q[k].size() != 0 || d[k] !== 1'b0 || ws[k] !== 1'b0 || wd[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle dut%0d: got data=%b start=%b done=%b pending=%0d want 0,0,0,0",
               k, d[k], ws[k], wd[k], q[k].size());
    end
    buffered = 1'b0;
    foreach (q[k][i]) if (q[k][i][1]) buffered = 1'b1;
    vectors++;
    if (rdy[k] !== !buffered) begin
      errors++;
      $display("FAIL in_ready dut%0d: got %b want %b", k, rdy[k], !buffered);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk(0);
    chk(1);
    if (rst) begin
      q[0].delete();
      q[1].delete();
    end else if (in_valid && rdy[0]) push(in_data);
  end

  task automatic send(input logic [W-1:0] w);
    logic ok;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ok = rdy[0];
      @(posedge clk);
      #1;
      if (ok) return;
    end
    errors++;
    $display("FAIL send_timeout: got no in_ready within 100 clks want accept of %h", w);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    run = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send(8'hA5);
    idle(12);
    send(8'h92);
    send(8'h49);
    idle(20);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(30);
    send(8'hFF);
    idle(4);
    pulse_rst();
    idle(2);
    send(8'h0F);
    idle(12);
    send(8'h01);
    idle(12);
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 10));
      if ($urandom_range(0, 60) == 0) pulse_rst();
      send(W'($urandom));
    end
    idle(30);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending bits want 0", k, q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
